// File: rtl/sale_pkg.sv
// Shared types and constants for the sale terminal entry sequencer:
// FSM state encoding, key bit positions, BCD digit type and small helpers.
package sale_pkg;

  // Transaction states; the numeric values are shown on the display.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ITEM  = 3'd1,
    ST_QTY   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_PAY   = 3'd4
  } sale_state_e;

  // Command key bit positions (cmd_keys).
  localparam int CMD_ENTER    = 0;
  localparam int CMD_CANCEL   = 1;
  localparam int CMD_CHECKOUT = 2;
  localparam int CMD_BACK     = 3;

  // Value key bit positions (val_keys).
  localparam int VAL_INC    = 0;
  localparam int VAL_DEC    = 1;
  localparam int VAL_CURSOR = 2;
  localparam int VAL_CLEAR  = 3;

  // One decimal digit of the item code.
  typedef logic [3:0] bcd_t;

  // Increment a BCD digit modulo 10.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Decrement a BCD digit modulo 10.
  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  // Keep only the lowest set bit, giving lowest-index-wins arbitration.
  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  // Four-bit counter increment that sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registered rising-edge detector for the eight key levels. The previous
// level resets to 0, so a key held across reset release yields one event.
module key_edge_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lvl_i,
  output logic [7:0] rise_o
);

  logic [7:0] lvl_q;

  // Remember last cycle's key levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/sale_entry_sequencer.sv
// Keypad transaction sequencer for the sale terminal: turns key levels into
// single events, arbitrates them, and runs item/quantity entry plus the cart
// and checkout handshakes, with an idle-entry timeout in ITEM and QTY.
module sale_entry_sequencer
  import sale_pkg::*;
#(
  parameter int MAX_QTY        = 9,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cmd_keys,
  input  logic [3:0] val_keys,
  output logic [7:0] item_bcd,
  output logic [3:0] qty,
  output logic       cursor,
  output logic       item_valid,
  input  logic       item_ready,
  output logic       checkout_valid,
  input  logic       checkout_ready,
  output logic [3:0] item_count,
  output logic       cancel_pulse,
  output logic       timeout_pulse,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ITEM  = ST_ITEM;
  localparam logic [2:0] S_QTY   = ST_QTY;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_PAY   = ST_PAY;

  localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     QTY_MAX  = 4'(MAX_QTY);

  logic [7:0]    rise;
  logic [3:0]    cmd_ev, val_ev;
  logic [3:0]    sel_cmd, sel_val;
  logic          accept;

  logic [2:0]    state_q, state_d;
  bcd_t          tens_q, tens_d;
  bcd_t          ones_q, ones_d;
  logic [3:0]    qty_q, qty_d;
  logic          cursor_q, cursor_d;
  logic [3:0]    count_q, count_d;
  logic          cancel_q, cancel_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] tmo_q, tmo_d;

  key_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .lvl_i  ({val_keys, cmd_keys}),
    .rise_o (rise)
  );

  assign cmd_ev = rise[3:0];
  assign val_ev = rise[7:4];

  // Pick at most one event: any command beats any value key, lowest bit wins.
  always_comb begin
    sel_cmd = lowest_set(cmd_ev);
    sel_val = (cmd_ev == 4'd0) ? lowest_set(val_ev) : 4'd0;
  end

  // Transaction FSM and entry registers; the timeout yields to accepted events.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    qty_d     = qty_q;
    cursor_d  = cursor_q;
    count_d   = count_q;
    cancel_d  = 1'b0;
    timeout_d = 1'b0;
    accept    = 1'b0;
    tmo_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (sel_cmd[CMD_ENTER]) begin
          state_d  = S_ITEM;
          tens_d   = 4'd0;
          ones_d   = 4'd0;
          cursor_d = 1'b0;
        end else if (sel_cmd[CMD_CHECKOUT]) begin
          if (count_q != 4'd0) state_d = S_PAY;
        end else if (sel_cmd[CMD_CANCEL]) begin
          count_d  = 4'd0;
          cancel_d = 1'b1;
        end
      end

      S_ITEM: begin
        if (sel_cmd[CMD_ENTER]) begin
          // A zero item code is not a valid product, so ENTER is ignored.
          if ({tens_q, ones_q} != 8'h00) begin
            state_d = S_QTY;
            qty_d   = 4'd1;
            accept  = 1'b1;
          end
        end else if (sel_cmd[CMD_CANCEL]) begin
          state_d  = S_IDLE;
          count_d  = 4'd0;
          cancel_d = 1'b1;
          accept   = 1'b1;
        end else if (sel_cmd[CMD_BACK]) begin
          state_d = S_IDLE;
          accept  = 1'b1;
        end else if (sel_val[VAL_INC]) begin
          if (cursor_q) tens_d = bcd_inc(tens_q);
          else          ones_d = bcd_inc(ones_q);
          accept = 1'b1;
        end else if (sel_val[VAL_DEC]) begin
          if (cursor_q) tens_d = bcd_dec(tens_q);
          else          ones_d = bcd_dec(ones_q);
          accept = 1'b1;
        end else if (sel_val[VAL_CURSOR]) begin
          cursor_d = ~cursor_q;
          accept   = 1'b1;
        end else if (sel_val[VAL_CLEAR]) begin
          tens_d   = 4'd0;
          ones_d   = 4'd0;
          cursor_d = 1'b0;
          accept   = 1'b1;
        end
      end

      S_QTY: begin
        if (sel_cmd[CMD_ENTER]) begin
          state_d = S_ISSUE;
          accept  = 1'b1;
        end else if (sel_cmd[CMD_CANCEL]) begin
          state_d  = S_IDLE;
          count_d  = 4'd0;
          cancel_d = 1'b1;
          accept   = 1'b1;
        end else if (sel_cmd[CMD_BACK]) begin
          state_d = S_ITEM;
          accept  = 1'b1;
        end else if (sel_val[VAL_INC]) begin
          qty_d  = (qty_q >= QTY_MAX) ? 4'd1 : qty_q + 4'd1;
          accept = 1'b1;
        end else if (sel_val[VAL_DEC]) begin
          qty_d  = (qty_q <= 4'd1) ? QTY_MAX : qty_q - 4'd1;
          accept = 1'b1;
        end else if (sel_val[VAL_CLEAR]) begin
          qty_d  = 4'd1;
          accept = 1'b1;
        end
      end

      S_ISSUE: begin
        // Keys are ignored here; only the cart transfer leaves the state.
        if (item_ready) begin
          state_d = S_IDLE;
          count_d = sat_inc4(count_q);
        end
      end

      S_PAY: begin
        if (checkout_ready) begin
          state_d = S_IDLE;
          count_d = 4'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Idle-entry timeout: only counts while the operator is entering data.
    if (state_q == S_ITEM || state_q == S_QTY) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // State, entry data, cart count, pulses and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      qty_q     <= 4'd1;
      cursor_q  <= 1'b0;
      count_q   <= 4'd0;
      cancel_q  <= 1'b0;
      timeout_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      qty_q     <= qty_d;
      cursor_q  <= cursor_d;
      count_q   <= count_d;
      cancel_q  <= cancel_d;
      timeout_q <= timeout_d;
      tmo_q     <= tmo_d;
    end
  end

  assign item_bcd       = {tens_q, ones_q};
  assign qty            = qty_q;
  assign cursor         = cursor_q;
  assign item_valid     = (state_q == S_ISSUE);
  assign checkout_valid = (state_q == S_PAY);
  assign item_count     = count_q;
  assign cancel_pulse   = cancel_q;
  assign timeout_pulse  = timeout_q;
  assign state          = state_q;

endmodule

// File: tb/tb_sale_entry_sequencer.sv
// Self-checking bench for sale_entry_sequencer: a vector table of key presses
// with expected entry state, a transfer scoreboard for the cart handshake, and
// hand-written sequences for timeout, cancel, checkout and reset corners.
module tb_sale_entry_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cmd_keys, val_keys;
  logic [7:0] item_bcd;
  logic [3:0] qty;
  logic       cursor;
  logic       item_valid, item_ready;
  logic       checkout_valid, checkout_ready;
  logic [3:0] item_count;
  logic       cancel_pulse, timeout_pulse;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  typedef struct {
    logic [3:0] c;
    logic [3:0] v;
    int st;
    int bcd;
    int q;
    int cur;
  } vec_t;

  typedef struct { int st; int bcd; int q; int cur; } exp_t;
  typedef struct { int bcd; int q; } xfer_t;

  vec_t  tbl [28];
  exp_t  exp_q [$];
  xfer_t xfer_q [$];

  sale_entry_sequencer #(.MAX_QTY(9), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_keys       (cmd_keys),
    .val_keys       (val_keys),
    .item_bcd       (item_bcd),
    .qty            (qty),
    .cursor         (cursor),
    .item_valid     (item_valid),
    .item_ready     (item_ready),
    .checkout_valid (checkout_valid),
    .checkout_ready (checkout_ready),
    .item_count     (item_count),
    .cancel_pulse   (cancel_pulse),
    .timeout_pulse  (timeout_pulse),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One key press: level high for one cycle, then released.
  task automatic press(input logic [3:0] c, input logic [3:0] v);
    @(posedge clk); #1;
    cmd_keys = c;
    val_keys = v;
    @(posedge clk); #1;
    cmd_keys = 4'd0;
    val_keys = 4'd0;
  endtask

  task automatic run_row(input int i);
    exp_t e;
    exp_q.push_back('{tbl[i].st, tbl[i].bcd, tbl[i].q, tbl[i].cur});
    if (tbl[i].st == 3) xfer_q.push_back('{tbl[i].bcd, tbl[i].q});
    press(tbl[i].c, tbl[i].v);
    e = exp_q.pop_front();
    chk($sformatf("row%0d.state", i), int'(state), e.st);
    chk($sformatf("row%0d.bcd", i), int'(item_bcd), e.bcd);
    chk($sformatf("row%0d.qty", i), int'(qty), e.q);
    chk($sformatf("row%0d.cursor", i), int'(cursor), e.cur);
    chk($sformatf("row%0d.item_valid", i), int'(item_valid), (e.st == 3) ? 1 : 0);
    chk($sformatf("row%0d.checkout_valid", i), int'(checkout_valid), (e.st == 4) ? 1 : 0);
  endtask

  // Cart transfer: wait n cycles in ISSUE, then one cycle of ready.
  task automatic handshake(input int n);
    xfer_t x;
    chk("hs.valid_before", int'(item_valid), 1);
    repeat (n) @(posedge clk);
    #1 item_ready = 1'b1;
    @(negedge clk);
    if (item_valid && item_ready && xfer_q.size() > 0) begin
      x = xfer_q.pop_front();
      chk("hs.bcd", int'(item_bcd), x.bcd);
      chk("hs.qty", int'(qty), x.q);
    end else begin
      chk("hs.transfer_seen", 0, 1);
    end
    @(posedge clk); #1;
    item_ready = 1'b0;
    ecnt = (ecnt >= 15) ? 15 : ecnt + 1;
    chk("hs.state_after", int'(state), 0);
    chk("hs.valid_after", int'(item_valid), 0);
    chk("hs.count", int'(item_count), ecnt);
  endtask

  // Add one item with the given units digit (1..9) and qty = 1 + incs.
  task automatic add_item(input int units, input int incs);
    press(4'h1, 4'h0);
    repeat (units) press(4'h0, 4'h1);
    press(4'h1, 4'h0);
    repeat (incs) press(4'h0, 4'h1);
    xfer_q.push_back('{units, 1 + incs});
    press(4'h1, 4'h0);
    chk("add.issue", int'(state), 3);
    handshake(1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".bcd"}, int'(item_bcd), 0);
    chk({tag, ".qty"}, int'(qty), 1);
    chk({tag, ".cursor"}, int'(cursor), 0);
    chk({tag, ".count"}, int'(item_count), 0);
    chk({tag, ".valids"}, int'({item_valid, checkout_valid}), 0);
    chk({tag, ".pulses"}, int'({cancel_pulse, timeout_pulse}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_to;
    int n_to;

    // Main entry path: item 23, qty 5.
    tbl[0]  = '{4'h4, 4'h0, 0, 'h00, 1, 0};
    tbl[1]  = '{4'h1, 4'h0, 1, 'h00, 1, 0};
    tbl[2]  = '{4'h0, 4'h1, 1, 'h01, 1, 0};
    tbl[3]  = '{4'h0, 4'h1, 1, 'h02, 1, 0};
    tbl[4]  = '{4'h0, 4'h1, 1, 'h03, 1, 0};
    tbl[5]  = '{4'h0, 4'h4, 1, 'h03, 1, 1};
    tbl[6]  = '{4'h0, 4'h1, 1, 'h13, 1, 1};
    tbl[7]  = '{4'h0, 4'h1, 1, 'h23, 1, 1};
    tbl[8]  = '{4'h1, 4'h0, 2, 'h23, 1, 1};
    tbl[9]  = '{4'h0, 4'h1, 2, 'h23, 2, 1};
    tbl[10] = '{4'h0, 4'h1, 2, 'h23, 3, 1};
    tbl[11] = '{4'h0, 4'h1, 2, 'h23, 4, 1};
    tbl[12] = '{4'h0, 4'h1, 2, 'h23, 5, 1};
    tbl[13] = '{4'h1, 4'h0, 3, 'h23, 5, 1};
    // Priority, zero-code ENTER, digit and quantity wrap, BACK paths.
    tbl[14] = '{4'h1, 4'h1, 1, 'h00, 5, 0};
    tbl[15] = '{4'h1, 4'h0, 1, 'h00, 5, 0};
    tbl[16] = '{4'h0, 4'h2, 1, 'h09, 5, 0};
    tbl[17] = '{4'h0, 4'h3, 1, 'h00, 5, 0};
    tbl[18] = '{4'h0, 4'h1, 1, 'h01, 5, 0};
    tbl[19] = '{4'h1, 4'h0, 2, 'h01, 1, 0};
    tbl[20] = '{4'h0, 4'h2, 2, 'h01, 9, 0};
    tbl[21] = '{4'h0, 4'h1, 2, 'h01, 1, 0};
    tbl[22] = '{4'h0, 4'h2, 2, 'h01, 9, 0};
    tbl[23] = '{4'h0, 4'h8, 2, 'h01, 1, 0};
    tbl[24] = '{4'h0, 4'h4, 2, 'h01, 1, 0};
    tbl[25] = '{4'h8, 4'h0, 1, 'h01, 1, 0};
    tbl[26] = '{4'h0, 4'h8, 1, 'h00, 1, 0};
    tbl[27] = '{4'h8, 4'h0, 0, 'h00, 1, 0};

    rst = 1'b1;
    cmd_keys = 4'd0;
    val_keys = 4'd0;
    item_ready = 1'b0;
    checkout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_values("reset");

    for (int i = 0; i < 14; i++) run_row(i);
    handshake(2);
    for (int i = 14; i < 28; i++) run_row(i);
    chk("tbl.count", int'(item_count), ecnt);

    // Timeout: ENTER then 16 idle cycles.
    press(4'h1, 4'h0);
    chk("to.item", int'(state), 1);
    first_to = -1;
    n_to = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (timeout_pulse) begin
        n_to++;
        if (first_to < 0) first_to = i;
      end
    end
    chk("to.cycle", first_to, 16);
    chk("to.pulses", n_to, 1);
    chk("to.state", int'(state), 0);
    chk("to.count", int'(item_count), ecnt);

    // Cancel with three items in the cart.
    add_item(2, 0);
    add_item(5, 2);
    chk("cn.count_pre", int'(item_count), 3);
    press(4'h2, 4'h0);
    chk("cn.pulse", int'(cancel_pulse), 1);
    chk("cn.count", int'(item_count), 0);
    chk("cn.state", int'(state), 0);
    @(posedge clk); #1;
    chk("cn.pulse_end", int'(cancel_pulse), 0);
    ecnt = 0;

    // Checkout held off for 10 cycles, CANCEL ignored meanwhile.
    add_item(7, 1);
    press(4'h4, 4'h0);
    chk("pay.state", int'(state), 4);
    chk("pay.valid", int'(checkout_valid), 1);
    repeat (3) @(posedge clk);
    #1;
    press(4'h2, 4'h0);
    chk("pay.no_cancel", int'(cancel_pulse), 0);
    chk("pay.state_hold", int'(state), 4);
    repeat (4) @(posedge clk);
    #1;
    chk("pay.valid_hold", int'(checkout_valid), 1);
    chk("pay.count_hold", int'(item_count), 1);
    checkout_ready = 1'b1;
    @(posedge clk); #1;
    checkout_ready = 1'b0;
    ecnt = 0;
    chk("pay.state_after", int'(state), 0);
    chk("pay.count_after", int'(item_count), 0);
    chk("pay.valid_after", int'(checkout_valid), 0);

    // Reset asserted while ISSUE is waiting: valid drops at once, nothing counted.
    press(4'h1, 4'h0);
    press(4'h0, 4'h1);
    press(4'h1, 4'h0);
    press(4'h1, 4'h0);
    chk("rs.issue", int'(item_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("rs.valid_async", int'(item_valid), 0);
    chk("rs.state_async", int'(state), 0);
    xfer_q.delete();
    cmd_keys = 4'h1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_values("rs");
    @(posedge clk); #1;
    chk("rs.held_key_event", int'(state), 1);
    cmd_keys = 4'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sale_entry_sequencer.md
# sale_entry_sequencer

Sequences the operator's keypad activity for the sale terminal. It takes the command and value key levels already split by the button-management stage, turns them into single-cycle key events, and runs the transaction state machine: item-code entry, quantity entry, cart handoff and checkout handoff. Its outputs go to the cart/pricing block over valid/ready handshakes and to the display layer as status.

## Interface

Parameters:
- `MAX_QTY`, default 9: largest quantity per entry, range 1..9.
- `TIMEOUT_CYCLES`, default 500_000_000: idle-entry timeout, 10 s at 50 MHz.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_keys` in 4: command key levels, 1 = pressed. Bit 0 ENTER, bit 1 CANCEL, bit 2 CHECKOUT, bit 3 BACK.
- `val_keys` in 4: value key levels, 1 = pressed. Bit 0 INC, bit 1 DEC, bit 2 CURSOR, bit 3 CLEAR.
- `item_bcd` out 8: item code, two BCD digits; [7:4] tens, [3:0] units.
- `qty` out 4: quantity being entered or issued.
- `cursor` out 1: 0 = units digit selected, 1 = tens digit selected.
- `item_valid` out 1: cart handshake valid.
- `item_ready` in 1: cart handshake ready.
- `checkout_valid` out 1: checkout handshake valid.
- `checkout_ready` in 1: checkout handshake ready.
- `item_count` out 4: items added since the last checkout or cancel; saturates at 15.
- `cancel_pulse` out 1: one-cycle pulse when a transaction is cancelled.
- `timeout_pulse` out 1: one-cycle pulse when an entry times out.
- `state` out 3: current FSM state, for display.

## Operation

- **Key events.** An event is a 0→1 transition of a key level, detected against a registered copy of the level. A held key produces exactly one event.
- **Event priority.** At most one event is acted on per cycle.
  - Any command event beats any value event.
  - Within each group, the lowest bit index wins.
  - Events that lose, or that arrive in a state which ignores them, are dropped, not queued.
- **IDLE**
  - ENTER → ITEM with `item_bcd`=0x00, `cursor`=0.
  - CHECKOUT with `item_count`>0 → PAY; with `item_count`=0 it is ignored.
  - CANCEL → clears `item_count` and pulses `cancel_pulse`; stays in IDLE.
  - All other events are ignored.
- **ITEM**
  - INC/DEC change the selected digit modulo 10 (9→0 and 0→9).
  - CURSOR toggles `cursor`.
  - CLEAR sets both digits to 0 and `cursor` to 0.
  - ENTER with a code other than 00 → QTY with `qty`=1. ENTER with code 00 is ignored.
  - BACK → IDLE; the cart is kept.
  - CANCEL → IDLE, clears `item_count`, pulses `cancel_pulse`.
- **QTY**
  - INC: `qty` steps up; `MAX_QTY` wraps to 1.
  - DEC: `qty` steps down; 1 wraps to `MAX_QTY`.
  - CLEAR sets `qty`=1.
  - CURSOR is ignored.
  - ENTER → ISSUE.
  - BACK → ITEM with digits retained.
  - CANCEL: same as in ITEM.
- **ISSUE**
  - `item_valid`=1, with `item_bcd` and `qty` held stable.
  - When `item_ready`=1 → IDLE and `item_count` increments, saturating at 15.
  - All key events are ignored, including CANCEL.
- **PAY**
  - `checkout_valid`=1.
  - When `checkout_ready`=1 → IDLE and `item_count` clears.
  - All key events are ignored.
- **Timeout**
  - A counter runs in ITEM and QTY and reloads on any accepted event.
  - On reaching `TIMEOUT_CYCLES`-1 → IDLE, `timeout_pulse` fires, `item_count` is unchanged.
  - The counter is held at 0 in all other states.
  - If a timeout and an accepted event fall in the same cycle, the event wins.
- **`state` encoding:** IDLE=0, ITEM=1, QTY=2, ISSUE=3, PAY=4.

## Timing

- Reset values: `state`=IDLE, `item_bcd`=0x00, `qty`=1, `cursor`=0, `item_count`=0, all valids and pulses 0. Edge-detect registers reset to 0, so a key already held when reset releases produces an event.
- Latency: a key level rising in cycle N is registered in N; the resulting state or register update is visible in N+1.
- Handshake:
  - A valid rises the cycle after entering ISSUE or PAY.
  - Transfer happens on the rising clock edge where valid and ready are both 1; valid is 0 in the following cycle.
  - Ready asserted while valid is 0 has no effect.
- Reset asserted mid-handshake drops valid asynchronously. No transfer is counted.
- `cancel_pulse` and `timeout_pulse` are registered and last exactly one cycle.

## Structure

- Shared package `sale_pkg` holds:
  - the state enum;
  - key index constants (`CMD_ENTER`..`CMD_BACK`, `VAL_INC`..`VAL_CLEAR`);
  - the BCD digit type.
- Sub-module `key_edge_detect`: 8-bit registered rising-edge detector, async reset, one instance covering both key vectors.
- The timeout counter is `$clog2(TIMEOUT_CYCLES)` bits wide.

## Test plan

- Reset, then ENTER; INC×3; CURSOR; INC×2; ENTER; INC×4; ENTER; `item_ready` after 2 cycles → `item_valid` with `item_bcd`=0x23, `qty`=5; `item_count`=1; back in IDLE.
- In ITEM, DEC from 0 → 9. In QTY, DEC from 1 → `MAX_QTY`; INC at `MAX_QTY` → 1.
- ENTER then ENTER with code 00 → stays in ITEM. CHECKOUT in IDLE with `item_count`=0 → stays in IDLE, `checkout_valid`=0.
- ENTER and INC events in the same cycle → only ENTER acted on. INC and DEC in the same cycle → only INC.
- `TIMEOUT_CYCLES`=16: ENTER, then no keys for 16 cycles → `timeout_pulse` once, IDLE, `item_count` unchanged. CANCEL with `item_count`=3 → `cancel_pulse`, `item_count`=0.
- PAY with `checkout_ready` held low for 10 cycles, CANCEL pressed meanwhile → `checkout_valid` stays high. `rst` pulsed → IDLE with all reset values.
